vec3_op_sequencer: RTL and testbench

- Command-driven sequencer that executes vec3 operations for the ray marcher: ADD, SCALE, DOT and CROSS.
- All multiplies go through one shared fixed-point multiplier with a registered product, one multiply issued per cycle.
- Sits between the march-step control logic and the vector datapath.
- Accepts one command at a time over a valid/ready input and returns one vec3 result over a valid/ready output.

---
 rtl/vec3_op_sequencer.sv | 99 +++++++++
 tb/tb_vec3_op_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vec3_op_sequencer.sv
// vec3_op_sequencer: runs ADD/SCALE/DOT/CROSS on vec3 operands through one shared fixed-point multiplier.
// Multiply ops spend N issue cycles plus one drain cycle in MUL so the last product is written back before WB.
module vec3_op_sequencer #(
    parameter int WORD_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [3*WORD_WIDTH-1:0] in_a,
    input  logic [3*WORD_WIDTH-1:0] in_b,
    input  logic [WORD_WIDTH-1:0]   in_s,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*WORD_WIDTH-1:0] out_res,
    output logic                    busy
);
    localparam int W = WORD_WIDTH;
    typedef enum logic [1:0] {IDLE, MUL, WB, DONE} state_t;
    state_t                state_q;
    logic [1:0]            op_q;
    logic signed [W-1:0]   a_q [3];
    logic signed [W-1:0]   b_q [3];
    logic signed [W-1:0]   s_q;
    logic [W-1:0]          res_q [3];
    logic [W-1:0]          p_q;
    logic [2:0]            k_q;
    logic                  out_valid_q;
    logic [2:0]            n;
    logic [1:0]            kk;
    logic [1:0]            ai;
    logic [1:0]            bi;
    logic signed [W-1:0]   ma;
    logic signed [W-1:0]   mb;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          p_d;
    logic [2:0]            j;
    logic [1:0]            jc;
    logic [W-1:0]          wv;
    // k_q is the issue index; writeback targets product j = k_q-1
    always_comb begin
        n    = (op_q == 2'd3) ? 3'd6 : 3'd3;
        kk   = (k_q[1:0] == 2'd3) ? 2'd0 : k_q[1:0];
        ai   = (op_q != 2'd3) ? kk : (k_q == 3'd0 || k_q == 3'd5) ? 2'd1 : (k_q == 3'd1 || k_q == 3'd2) ? 2'd2 : 2'd0;
        bi   = (op_q != 2'd3) ? kk : (k_q == 3'd0 || k_q == 3'd3) ? 2'd2 : (k_q == 3'd1 || k_q == 3'd4) ? 2'd1 : 2'd0;
        ma   = a_q[ai];
        mb   = (op_q == 2'd1) ? s_q : b_q[bi];
        prod = ma * mb;
        p_d  = W'(prod >>> FRAC_BITS);
        j    = k_q - 3'd1;
        jc   = (op_q == 2'd3) ? j[2:1] : (op_q == 2'd2) ? 2'd0 : j[1:0];
        wv   = (op_q == 2'd2) ? res_q[0] + p_q : (op_q == 2'd3 && j[0]) ? res_q[jc] - p_q : p_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            k_q         <= '0;
            op_q        <= '0;
            for (int i = 0; i < 3; i++) res_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q    <= in_op;
                    s_q     <= in_s;
                    k_q     <= '0;
                    state_q <= (in_op == 2'd0) ? WB : MUL;
                    for (int i = 0; i < 3; i++) begin
                        a_q[i]   <= in_a[(2-i)*W +: W];
                        b_q[i]   <= in_b[(2-i)*W +: W];
                        res_q[i] <= (in_op == 2'd0) ? in_a[(2-i)*W +: W] + in_b[(2-i)*W +: W] : '0;
                    end
                end
                MUL: begin
                    if (k_q != 3'd0) res_q[jc] <= wv;
                    p_q <= p_d;
                    k_q <= k_q + 3'd1;
                    if (k_q == n) state_q <= WB;
                end
                WB: begin
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_res   = {res_q[0], res_q[1], res_q[2]};
endmodule

// File: tb/tb_vec3_op_sequencer.sv
// tb_vec3_op_sequencer: directed vector table, hand-written stall/reset/throughput sequences, and randomized commands against a fixed-point model.
module tb_vec3_op_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [95:0] in_a = '0;
    logic [95:0] in_b = '0;
    logic [31:0] in_s = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [95:0] out_res;
    logic        busy;
    int pass_cnt = 0;
    int total = 0;

    vec3_op_sequencer #(.WORD_WIDTH(32), .FRAC_BITS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [95:0] a;
        logic [95:0] b;
        logic [31:0] s;
        logic [95:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] fm(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 32'(p >>> 16);
    endfunction

    function automatic logic [95:0] model(input logic [1:0] op, input logic [95:0] a, input logic [95:0] b, input logic [31:0] s);
        logic [31:0] ax, ay, az, bx, by, bz;
        {ax, ay, az} = a;
        {bx, by, bz} = b;
        case (op)
            2'd0: return {ax + bx, ay + by, az + bz};
            2'd1: return {fm(ax, s), fm(ay, s), fm(az, s)};
            2'd2: return {fm(ax, bx) + fm(ay, by) + fm(az, bz), 32'd0, 32'd0};
            default: return {fm(ay, bz) - fm(az, by), fm(az, bx) - fm(ax, bz), fm(ax, by) - fm(ay, bx)};
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op);
        return (op == 2'd0) ? 1 : (op == 2'd3) ? 8 : 5;
    endfunction

    // Issues one command, scrambles inputs after accept, waits for the result and consumes it.
    task automatic run(input logic [1:0] op, input logic [95:0] a, input logic [95:0] b, input logic [31:0] s,
                       output logic [95:0] res, output int lat);
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_s = s; in_valid = 1'b1; out_ready = 1'b1;
        chk("in_ready_before_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_s = ~s; in_op = op + 2'd1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_res;
        @(posedge clk); #1;
    endtask

    vec_t tbl[7];
    logic [95:0] res, held;
    int lat;
    int acc[$];
    int bad;

    initial begin
        tbl[0] = '{2'd2, {32'h00010000, 32'h00020000, 32'h00030000}, {32'h00040000, 32'h00050000, 32'h00060000}, 32'h0,
                   {32'h00200000, 32'h0, 32'h0}, 5};
        tbl[1] = '{2'd3, {32'h00010000, 32'h0, 32'h0}, {32'h0, 32'h00010000, 32'h0}, 32'h0,
                   {32'h0, 32'h0, 32'h00010000}, 8};
        tbl[2] = '{2'd3, {32'h00020000, 32'h00030000, 32'h00040000}, {32'h00050000, 32'h00060000, 32'h00070000}, 32'h0,
                   {32'hFFFD0000, 32'h00060000, 32'hFFFD0000}, 8};
        tbl[3] = '{2'd1, {32'h00010000, 32'hFFFE0000, 32'h00008000}, {32'h11111111, 32'h22222222, 32'h33333333}, 32'h00020000,
                   {32'h00020000, 32'hFFFC0000, 32'h00010000}, 5};
        tbl[4] = '{2'd1, {32'hFFFFFFFF, 32'h0, 32'h0}, 96'h0, 32'h00008000,
                   {32'hFFFFFFFF, 32'h0, 32'h0}, 5};
        tbl[5] = '{2'd0, {32'h7FFFFFFF, 32'h0, 32'h0}, {32'h00000001, 32'h0, 32'h0}, 32'h0,
                   {32'h80000000, 32'h0, 32'h0}, 1};
        tbl[6] = '{2'd0, {32'hFFFF0000, 32'h00000005, 32'h80000000}, {32'h00030000, 32'hFFFFFFF0, 32'h80000000}, 32'h0,
                   {32'h00020000, 32'hFFFFFFF5, 32'h00000000}, 1};
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_res", out_res, 96'h0);
        for (int i = 0; i < 7; i++) begin
            run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s, res, lat);
            chk($sformatf("vec%0d_res", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_lat", i), 96'(lat), 96'(tbl[i].lat));
        end
        @(negedge clk);
        chk("dot_then_idle_in_ready", in_ready, 1'b1);
        // Back-to-back ADDs with out_ready high: accepted every third cycle.
        in_op = 2'd0; in_a = {32'd1, 32'd2, 32'd3}; in_b = {32'd4, 32'd5, 32'd6}; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (in_ready) acc.push_back(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accept_count", 96'(acc.size()), 96'd4);
        bad = 0;
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 3) bad++;
        chk("b2b_accept_spacing", 96'(bad), 96'd0);
        repeat (4) @(posedge clk);
        // Backpressure on a DOT, with a new command pending during the stall.
        @(negedge clk);
        in_op = 2'd2; in_a = tbl[0].a; in_b = tbl[0].b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_dot_lat", 96'(lat), 96'd5);
        chk("stall_dot_res", out_res, tbl[0].exp);
        held = out_res;
        @(negedge clk);
        in_op = 2'd0; in_a = {32'd10, 32'd20, 32'd30}; in_b = {32'd1, 32'd2, 32'd3}; in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid || out_res !== held || in_ready) bad++;
        end
        chk("stall_hold_violations", 96'(bad), 96'd0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_out_valid", out_valid, 1'b0);
        chk("stall_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stall_pending_accepted", busy, 1'b1);
        @(posedge clk); #1;
        chk("stall_pending_valid", out_valid, 1'b1);
        chk("stall_pending_res", out_res, {32'd11, 32'd22, 32'd33});
        @(posedge clk); #1;
        // Reset in the middle of a CROSS abandons it.
        @(negedge clk);
        in_op = 2'd3; in_a = tbl[2].a; in_b = tbl[2].b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk); rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("midrst_no_result", 96'(bad), 96'd0);
        run(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].s, res, lat);
        chk("midrst_dot_res", res, tbl[0].exp);
        chk("midrst_dot_lat", 96'(lat), 96'd5);
        // Randomized commands against the model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [95:0] a, b;
            logic [31:0] s;
            op = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom};
            s = $urandom;
            if (i % 2 == 0) begin
                a = {32'($signed(a[95:64]) >>> 8), 32'($signed(a[63:32]) >>> 8), 32'($signed(a[31:0]) >>> 8)};
                s = 32'($signed(s) >>> 10);
            end
            run(op, a, b, s, res, lat);
            chk($sformatf("rand%0d_op%0d_res", i, op), res, model(op, a, b, s));
            chk($sformatf("rand%0d_op%0d_lat", i, op), 96'(lat), 96'(model_lat(op)));
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
